audio_i2s_tx: RTL
=================

# audio_i2s_tx

Stereo I2S transmitter for the audio codec. It runs on the 50 MHz system clock from the clock manager, divides it into the codec bit clock (BCLK) and word clock (LRCLK), and serializes 16-bit left/right samples supplied through a valid/ready handshake. A one-entry holding register decouples the sample producer from the frame timing, and an underrun flag reports every frame that had no sample ready.

## Interface
- DIV, 16, BCLK half-period in CLK cycles, minimum 2. The default gives BCLK = 50 MHz / 32 = 1.5625 MHz and fs = BCLK / 32 ≈ 48.8 kHz.
- CLK  input  1  system clock (CLK_50M domain); all logic is on its rising edge.
- RST  input  1  synchronous, active-low reset.
- L_IN  input  16  left sample, two's complement.
- R_IN  input  16  right sample, two's complement.
- VALID  input  1  producer asserts when L_IN/R_IN hold a sample pair.
- READY  output  1  holding register empty; the pair is accepted on a CLK edge with VALID&READY.
- BCLK  output  1  codec bit clock.
- LRCLK  output  1  word select: 0 = left, 1 = right.
- SDATA  output  1  serial data, MSB first, I2S format (one-bit delay after LRCLK).
- UNDERRUN  output  1  one-CLK pulse when a frame starts with the holding register empty.

## Operation
- **Reset values** (RST=0 at a CLK edge): BCLK=0, LRCLK=0, SDATA=0, READY=1, UNDERRUN=0. Also divcnt=0, bitcnt=0, shift=0, and the holding register is empty.
- **Divider**: divcnt counts 0..DIV-1. When divcnt=DIV-1 it wraps to 0 and BCLK toggles.
  - Rise event: BCLK goes 0→1.
  - Fall event: BCLK goes 1→0.
- **Bit counter** (5 bits, wraps 31→0): increments on every fall event.
  - LRCLK is registered and updated on fall events: 0 while the new bitcnt is in 0..15, 1 while it is in 16..31.
- **Shift register** (32 bits) and SDATA = shift[31], registered.
  - **Load**: on the fall event where bitcnt goes 0→1.
    - Holding full: shift ← {L_hold, R_hold} and the holding register empties.
    - Holding empty: shift ← 0 and UNDERRUN=1 for that one CLK cycle.
  - **Shift**: on every other fall event, shift ← {shift[30:0], 0}.
- **Resulting bit placement**:
  - Left MSB is driven at bitcnt=1; left LSB at bitcnt=16, while LRCLK is already 1.
  - Right MSB is driven at bitcnt=17; right LSB at bitcnt=0 of the following frame.
- **Handshake**:
  - READY = holding empty, registered.
  - On VALID&READY, capture L_IN/R_IN into the holding register; READY=0 from the next cycle.
  - VALID while READY=0 is ignored; the producer must hold the data.
- **Simultaneous load and accept**: this can only occur with the holding register empty (READY=1).
  - The load uses the pre-edge holding content, so it sends zeros and pulses UNDERRUN.
  - The accepted pair fills the holding register for the next frame.
- **Holding full at load**: the holding register empties and READY=1 on the next cycle. No accept can occur on the load edge itself.
- **RST low mid-frame**: everything returns to the reset values on that edge. The partial frame is abandoned and the held sample is discarded.

## Timing
- Rise events occur at CLK edges DIV, 3·DIV, 5·DIV…; fall events at 2·DIV, 4·DIV… after reset release.
- The first frame load is at edge 2·DIV. A pair accepted on or before edge 2·DIV−1 is sent in frame 0.
- Frame = 32 BCLK = 64·DIV CLK cycles. Loads occur every 64·DIV cycles.
- SDATA and LRCLK change only on fall-event edges. The codec samples on BCLK rise, DIV cycles later.
- Producer latency budget: at most one pair per frame. READY rises one cycle after each load.

## Test plan
- **Reset**: hold RST=0 for 5 cycles with VALID=1 → all outputs at reset values, READY=1, no BCLK toggles.
- **Single frame**, DIV=2: accept L=16'hA5C3, R=16'h0F01 at cycle 1 → UNDERRUN stays 0.
  - SDATA sampled on BCLK rises at bitcnt 1..16 = A5C3 MSB-first; 17..31 plus the next frame's 0 = 0F01.
  - LRCLK goes 1 at the fall where bitcnt becomes 16.
- **Underrun**: no VALID after reset → UNDERRUN pulses at cycles 2·DIV and 2·DIV+64·DIV; SDATA stays 0.
- **Backpressure**: VALID held high with incrementing data → exactly one accept per frame, READY low between loads, no pair skipped or duplicated over 8 frames.
- **Simultaneous**: VALID first asserted at edge 2·DIV → UNDERRUN on that edge, frame 0 all zeros, frame 1 carries the pair.
- **Mid-frame reset**: RST=0 at bitcnt=9 → next cycle matches reset values; the next frame starts 2·DIV after release with an underrun.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: divides CLK into BCLK/LRCLK and serializes
// 16-bit left/right pairs taken from a one-entry holding register.
module audio_i2s_tx #(
    parameter int DIV = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] L_IN,
    input  logic [15:0] R_IN,
    input  logic        VALID,
    output logic        READY,
    output logic        BCLK,
    output logic        LRCLK,
    output logic        SDATA,
    output logic        UNDERRUN
);

    localparam logic [15:0] DIV_TOP = 16'(DIV - 1);

    logic [15:0] divcnt;
    logic [4:0]  bitcnt;
    logic [4:0]  bit_nxt;
    logic [31:0] shift;
    logic [15:0] l_hold;
    logic [15:0] r_hold;
    logic        full;
    logic        tick;
    logic        fall;
    logic        load;
    logic        accept;

    assign tick    = (divcnt == DIV_TOP);
    assign fall    = tick & BCLK;
    assign load    = fall & (bitcnt == 5'd0);
    assign accept  = VALID & READY;
    assign bit_nxt = bitcnt + 5'd1;

    // full and shift are registers, so both outputs stay glitch-free
    assign READY = ~full;
    assign SDATA = shift[31];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            divcnt   <= '0;
            bitcnt   <= '0;
            shift    <= '0;
            l_hold   <= '0;
            r_hold   <= '0;
            full     <= 1'b0;
            BCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            UNDERRUN <= 1'b0;
            divcnt   <= tick ? '0 : divcnt + 16'd1;
            if (tick) begin
                BCLK <= ~BCLK;
            end
            if (fall) begin
                bitcnt <= bit_nxt;
                LRCLK  <= bit_nxt[4];
                if (bitcnt == 5'd0) begin
                    if (full) begin
                        shift <= {l_hold, r_hold};
                    end else begin
                        shift    <= '0;
                        UNDERRUN <= 1'b1;
                    end
                end else begin
                    shift <= {shift[30:0], 1'b0};
                end
            end
            // accept only happens when empty, so it never races a full load
            if (load && full) begin
                full <= 1'b0;
            end
            if (accept) begin
                full   <= 1'b1;
                l_hold <= L_IN;
                r_hold <= R_IN;
            end
        end
    end

endmodule
